alu_mc: RTL and testbench
=========================

# alu_mc

Parametrised multi-cycle ALU for the pipelined CPU's execute stage. It replaces the purely combinational ALU with a registered, handshaked unit. Single-cycle logic and arithmetic operations complete in one cycle; multiply, divide and remainder run on an iterative shift/add datapath. A valid/ready interface lets the pipeline stall while the unit is busy, and a flush input lets it kill an in-flight operation.

## Interface
- WIDTH, 32: operand and result width in bits; must be ≥ 4.
- OPW, 4: opcode width in bits.
- clk  in  1  clock; rising-edge active.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands and opcode present.
- in_ready  out  1  unit can accept an operation this cycle.
- op  in  OPW  operation code.
- in1, in2  in  WIDTH  operands.
- flush  in  1  abort the in-flight operation and drop any pending output.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out  out  WIDTH  result.
- zero  out  1  asserted exactly when out == 0.
- busy  out  1  an iterative operation is in progress.

## Operation
- Opcodes:
  - 0010 add; 0110 sub; 0000 and; 0001 or; 0011 xor; 1100 nor.
  - 0111 slt (signed); 1011 sltu (unsigned).
  - 1000 sll; 1001 srl; 1010 sra. Shift amount is in2[$clog2(WIDTH)-1:0].
  - 1101 mul: low WIDTH bits of the product.
  - 1110 divu: unsigned quotient; 1111 remu: unsigned remainder.
  - Any other code: result 0.
- Add and sub wrap modulo 2^WIDTH; no carry or overflow output.
- slt and sltu return 1 or 0, zero-extended to WIDTH.
- zero is computed from the final result for every opcode, including slt.
- Divide by zero: quotient = all ones; remainder = in1.
- FSM states:
  - IDLE → DONE: single-cycle op accepted.
  - IDLE → MUL: mul accepted. IDLE → DIV: divu or remu accepted.
  - MUL / DIV → DONE: after WIDTH iterations.
  - DONE → IDLE: on out_ready, or via a direct accept when handled in the same cycle.
- MUL: one shift-add step per cycle, consuming one multiplier bit per step.
- DIV: restoring division, one quotient bit per cycle.
- Operands are latched on acceptance, so in1, in2 and op may change afterwards.
- in_ready = (state == IDLE) || (state == DONE && out_ready).
- busy = 1 in MUL or DIV.
- out and zero hold their values until the handshake completes.
- flush has priority over every other input:
  - next state = IDLE; out_valid drops next cycle.
  - The result is discarded, and an in_valid presented in the same cycle is ignored.

## Timing
- Reset values: state IDLE; out_valid 0; out 0; zero 0; busy 0.
  - in_ready reflects the IDLE state combinationally during reset.
- Single-cycle ops: accepted at edge N; out_valid = 1 after edge N.
- Iterative ops: accepted at edge N; busy during cycles N+1 … N+WIDTH; out_valid after edge N+WIDTH+1.
- Back-to-back: while out_ready = 1, a new op can be accepted in the same cycle the old result is taken.
  - Single-cycle ops therefore sustain one result per cycle.
- out_ready = 0 in DONE: out, zero and out_valid stay stable and in_ready = 0.
- Reset asserted mid-operation clears immediately; the partial result is lost.
- flush and the output handshake in the same cycle: flush wins; the result counts as not delivered.

## Configuration
- ALU_DIV_EN defined: DIV state, divider datapath and opcodes 1110/1111 are present.
- ALU_DIV_EN undefined: no DIV state or divider logic.
  - Opcodes 1110/1111 behave as undefined codes: single-cycle, result 0, zero 1.

## Structure
- Shared package alu_pkg holds:
  - the opcode localparams (ALU_ADD, ALU_SUB, ALU_AND, …);
  - the FSM state enum;
  - a helper function is_iterative(op).
- One natural sub-module, alu_mc_iter, holds the shared shift/add multiply/divide datapath:
  - accumulator and operand shift registers;
  - iteration counter of $clog2(WIDTH)+1 bits;
  - start/done pulses.
- The top level contains the FSM, the single-cycle logic, the result mux and the output register.

## Test plan
- WIDTH = 32, add 0xFFFFFFFF + 1 → out 0, zero 1, out_valid one cycle after acceptance. Then sub 5 − 7 → 0xFFFFFFFE, zero 0.
- slt −1 < 1 → 1; sltu 0xFFFFFFFF < 1 → 0; sra 0x80000000 by 4 → 0xF8000000.
- mul 0x00010001 × 0x00010001 → 0x00020001 after edge N+33. busy is high for exactly 32 cycles and in_ready is low throughout.
- divu 100 / 7 → 14; remu → 2. divu 5 / 0 → 0xFFFFFFFF; remu 5 / 0 → 5. Repeat with ALU_DIV_EN undefined: divu → 0 in one cycle, zero 1.
- Hold out_ready low for 3 cycles after a result: out stays stable and in_ready stays 0. Then stream 4 adds with out_ready = 1: 4 results on 4 consecutive cycles.
- flush at iteration 10 of a mul → IDLE next cycle, no out_valid. Then assert rst_n = 0 mid-divide → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and op classification for the multi-cycle ALU.
// ALU_DIV_EN adds the DIV state and the divu/remu opcodes to the iterative set.
package alu_pkg;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_XOR  = 4'b0011;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_SLL  = 4'b1000;
   localparam logic [3:0] ALU_SRL  = 4'b1001;
   localparam logic [3:0] ALU_SRA  = 4'b1010;
   localparam logic [3:0] ALU_SLTU = 4'b1011;
   localparam logic [3:0] ALU_NOR  = 4'b1100;
   localparam logic [3:0] ALU_MUL  = 4'b1101;
   localparam logic [3:0] ALU_DIVU = 4'b1110;
   localparam logic [3:0] ALU_REMU = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
`ifdef ALU_DIV_EN
      ST_DIV  = 2'd3,
`endif
      ST_DONE = 2'd2
   } state_t;

   function automatic logic is_iterative(input logic [3:0] op);
`ifdef ALU_DIV_EN
      return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
`else
      return (op == ALU_MUL);
`endif
   endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// Iterative shift/add datapath: multiply, plus restoring divide under ALU_DIV_EN.
// Loads on start, steps WIDTH times (busy_o), then pulses done_o for one cycle.
module alu_mc_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             start,
`ifdef ALU_DIV_EN
   input  logic             div_sel,
   input  logic             rem_sel,
`endif
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] res_o
);

   localparam int CW = $clog2(WIDTH) + 1;

   // acc: product / partial remainder; a: multiplicand / dividend-quotient; b: multiplier / divisor
   logic [WIDTH-1:0] acc_q, acc_d, a_q, a_d, b_q, b_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             done_q, done_d;
`ifdef ALU_DIV_EN
   logic             div_q, div_d, rem_q, rem_d;
   logic [WIDTH:0]   trial, diff;
`endif

   always_comb begin
      acc_d  = acc_q;
      a_d    = a_q;
      b_d    = b_q;
      cnt_d  = cnt_q;
      done_d = 1'b0;
`ifdef ALU_DIV_EN
      div_d  = div_q;
      rem_d  = rem_q;
      trial  = {acc_q, a_q[WIDTH-1]};
      diff   = trial - {1'b0, b_q};
`endif
      if (flush) begin
         cnt_d = '0;
      end else if (start) begin
         acc_d = '0;
         a_d   = in1;
         b_d   = in2;
         cnt_d = CW'(WIDTH);
`ifdef ALU_DIV_EN
         div_d = div_sel;
         rem_d = rem_sel;
`endif
      end else if (cnt_q != '0) begin
         cnt_d  = cnt_q - CW'(1);
         done_d = (cnt_q == CW'(1));
`ifdef ALU_DIV_EN
         // A zero divisor never borrows, giving all-ones quotient and remainder = dividend
         if (div_q) begin
            if (!diff[WIDTH]) begin
               acc_d = diff[WIDTH-1:0];
               a_d   = {a_q[WIDTH-2:0], 1'b1};
            end else begin
               acc_d = trial[WIDTH-1:0];
               a_d   = {a_q[WIDTH-2:0], 1'b0};
            end
         end else
`endif
         begin
            if (b_q[0]) acc_d = acc_q + a_q;
            a_d = a_q << 1;
            b_d = b_q >> 1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q  <= '0;
         a_q    <= '0;
         b_q    <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
`ifdef ALU_DIV_EN
         div_q  <= 1'b0;
         rem_q  <= 1'b0;
`endif
      end else begin
         acc_q  <= acc_d;
         a_q    <= a_d;
         b_q    <= b_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
`ifdef ALU_DIV_EN
         div_q  <= div_d;
         rem_q  <= rem_d;
`endif
      end
   end

   assign busy_o = (cnt_q != '0);
   assign done_o = done_q;
`ifdef ALU_DIV_EN
   assign res_o  = (div_q && !rem_q) ? a_q : acc_q;
`else
   assign res_o  = acc_q;
`endif

endmodule

// File: rtl/alu_mc.sv
// Registered multi-cycle ALU: 1-cycle logic/arith, WIDTH+1 cycles for mul (and divu/remu with ALU_DIV_EN).
// Valid/ready both sides; result held until out_ready; flush kills in-flight work and pending output.
module alu_mc
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int OPW   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OPW-1:0]   op,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             zero,
   output logic             busy
);

   localparam int SHW = $clog2(WIDTH);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] out_q, out_d, alu_res, iter_res;
   logic             zero_q, zero_d, out_vld_q, out_vld_d;
   logic             accept, iter_start, iter_done, iter_busy;
   logic [SHW-1:0]   shamt;

   assign in_ready   = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
   assign accept     = in_valid && in_ready && !flush;
   assign iter_start = accept && is_iterative(op);
   assign shamt      = in2[SHW-1:0];

   always_comb begin
      alu_res = '0;
      case (op)
         ALU_ADD:  alu_res = in1 + in2;
         ALU_SUB:  alu_res = in1 - in2;
         ALU_AND:  alu_res = in1 & in2;
         ALU_OR:   alu_res = in1 | in2;
         ALU_XOR:  alu_res = in1 ^ in2;
         ALU_NOR:  alu_res = ~(in1 | in2);
         ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
         ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (in1 < in2)};
         ALU_SLL:  alu_res = in1 << shamt;
         ALU_SRL:  alu_res = in1 >> shamt;
         ALU_SRA:  alu_res = $signed(in1) >>> shamt;
         default:  alu_res = '0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      out_d     = out_q;
      zero_d    = zero_q;
      out_vld_d = out_vld_q;
      if (flush) begin
         state_d   = ST_IDLE;
         out_vld_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if ((state_q == ST_DONE) && out_ready) begin
                  state_d   = ST_IDLE;
                  out_vld_d = 1'b0;
               end
               if (accept) begin
                  if (is_iterative(op)) begin
`ifdef ALU_DIV_EN
                     state_d = (op == ALU_MUL) ? ST_MUL : ST_DIV;
`else
                     state_d = ST_MUL;
`endif
                     out_vld_d = 1'b0;
                  end else begin
                     state_d   = ST_DONE;
                     out_d     = alu_res;
                     zero_d    = (alu_res == '0);
                     out_vld_d = 1'b1;
                  end
               end
            end
            default: begin
               if (iter_done) begin
                  state_d   = ST_DONE;
                  out_d     = iter_res;
                  zero_d    = (iter_res == '0);
                  out_vld_d = 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         out_q     <= '0;
         zero_q    <= 1'b0;
         out_vld_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         out_q     <= out_d;
         zero_q    <= zero_d;
         out_vld_q <= out_vld_d;
      end
   end

   alu_mc_iter #(.WIDTH(WIDTH)) u_iter (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .start   (iter_start),
`ifdef ALU_DIV_EN
      .div_sel ((op == ALU_DIVU) || (op == ALU_REMU)),
      .rem_sel (op == ALU_REMU),
`endif
      .in1     (in1),
      .in2     (in2),
      .busy_o  (iter_busy),
      .done_o  (iter_done),
      .res_o   (iter_res)
   );

   assign out       = out_q;
   assign zero      = zero_q;
   assign out_valid = out_vld_q;
   assign busy      = iter_busy;

endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc at WIDTH=32; divide expectations follow ALU_DIV_EN.
module tb_alu_mc;
   import alu_pkg::*;

   localparam int W = 32;
`ifdef ALU_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif
   localparam int DLAT = DIV_EN ? W + 1 : 0;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [3:0]   op = 4'b0;
   logic [W-1:0] in1 = '0;
   logic [W-1:0] in2 = '0;
   logic         flush = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] out;
   logic         zero;
   logic         busy;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   alu_mc #(.WIDTH(W), .OPW(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .in1       (in1),
      .in2       (in2),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .zero      (zero),
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one op, wait for its result, check latency, busy span, in_ready, out and zero.
   task automatic run(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] exp, input int lat, input string tag);
      int n;
      int nb;
      int rdy;
      n = 0;
      nb = 0;
      rdy = 0;
      in_valid = 1'b1;
      op = o;
      in1 = a;
      in2 = b;
      while (!in_ready && n < 100) begin
         tick();
         n++;
      end
      tick();
      in_valid = 1'b0;
      op = ALU_ADD;
      in1 = 32'hDEAD_BEEF;
      in2 = 32'h1234_5678;
      n = 0;
      while (!out_valid && n < 100) begin
         if (busy) nb++;
         if (in_ready) rdy++;
         tick();
         n++;
      end
      chk({tag, ".lat"}, W'(n), W'(lat));
      chk({tag, ".busy_cyc"}, W'(nb), W'((lat == 0) ? 0 : W));
      chk({tag, ".rdy_while_busy"}, W'(rdy), '0);
      chk({tag, ".out"}, out, exp);
      chk({tag, ".zero"}, W'(zero), W'(exp == '0));
   endtask

   initial begin
      int cnt;
      repeat (3) tick();
      chk("rst.out_valid", W'(out_valid), '0);
      chk("rst.out", out, '0);
      chk("rst.zero", W'(zero), '0);
      chk("rst.busy", W'(busy), '0);
      chk("rst.in_ready", W'(in_ready), 32'd1);
      rst_n = 1'b1;
      tick();

      run(ALU_ADD,  32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 0, "add_wrap");
      run(ALU_SUB,  32'd5,         32'd7,         32'hFFFF_FFFE, 0, "sub");
      run(ALU_SLT,  32'hFFFF_FFFF, 32'd1,         32'd1,         0, "slt");
      run(ALU_SLTU, 32'hFFFF_FFFF, 32'd1,         32'd0,         0, "sltu");
      run(ALU_SRA,  32'h8000_0000, 32'd4,         32'hF800_0000, 0, "sra");
      run(ALU_SRL,  32'h8000_0000, 32'h0000_003F, 32'd1,         0, "srl_amt_mask");
      run(ALU_SLL,  32'd1,         32'd31,        32'h8000_0000, 0, "sll");
      run(ALU_XOR,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 0, "xor");
      run(ALU_NOR,  32'd0,         32'd0,         32'hFFFF_FFFF, 0, "nor");
      run(4'b0100,  32'd9,         32'd9,         32'd0,         0, "undef_op");
      run(ALU_MUL,  32'h0001_0001, 32'h0001_0001, 32'h0002_0001, W + 1, "mul");
      run(ALU_MUL,  32'hFFFF_FFFF, 32'd3,         32'hFFFF_FFFD, W + 1, "mul_neg");
      run(ALU_DIVU, 32'd100, 32'd7, DIV_EN ? 32'd14 : 32'd0,        DLAT, "divu");
      run(ALU_REMU, 32'd100, 32'd7, DIV_EN ? 32'd2 : 32'd0,         DLAT, "remu");
      run(ALU_DIVU, 32'd5,   32'd0, DIV_EN ? 32'hFFFF_FFFF : 32'd0, DLAT, "divu_by0");
      run(ALU_REMU, 32'd5,   32'd0, DIV_EN ? 32'd5 : 32'd0,         DLAT, "remu_by0");

      // Stall: result held with out_ready low, operands changed after acceptance
      tick();
      out_ready = 1'b0;
      in_valid = 1'b1;
      op = ALU_ADD;
      in1 = 32'd3;
      in2 = 32'd4;
      tick();
      in_valid = 1'b0;
      in1 = 32'd99;
      for (int k = 0; k < 3; k++) begin
         chk("stall.out", out, 32'd7);
         chk("stall.out_valid", W'(out_valid), 32'd1);
         chk("stall.in_ready", W'(in_ready), '0);
         tick();
      end

      // Stream four adds, one result per cycle
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         op = ALU_ADD;
         in1 = W'(i * 16);
         in2 = W'(i + 1);
         tick();
         chk("stream.out_valid", W'(out_valid), 32'd1);
         chk("stream.out", out, W'(i * 16 + i + 1));
      end
      in_valid = 1'b0;
      tick();
      chk("stream.drain", W'(out_valid), '0);

      // Flush during iteration 10 of a multiply
      in_valid = 1'b1;
      op = ALU_MUL;
      in1 = 32'd3;
      in2 = 32'd5;
      tick();
      in_valid = 1'b0;
      repeat (9) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush.in_ready", W'(in_ready), 32'd1);
      chk("flush.busy", W'(busy), '0);
      chk("flush.out_valid", W'(out_valid), '0);
      cnt = 0;
      for (int k = 0; k < 40; k++) begin
         if (out_valid) cnt++;
         tick();
      end
      chk("flush.no_result", W'(cnt), '0);

      // flush beats a simultaneous in_valid
      flush = 1'b1;
      in_valid = 1'b1;
      op = ALU_ADD;
      in1 = 32'd1;
      in2 = 32'd1;
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      chk("flush_in.out_valid", W'(out_valid), '0);

      // Asynchronous reset in the middle of a divide
      in_valid = 1'b1;
      op = ALU_DIVU;
      in1 = 32'd100;
      in2 = 32'd7;
      tick();
      in_valid = 1'b0;
      repeat (5) tick();
      chk("rdiv.busy_pre", W'(busy), W'(DIV_EN));
      rst_n = 1'b0;
      #1;
      chk("rdiv.out_valid", W'(out_valid), '0);
      chk("rdiv.out", out, '0);
      chk("rdiv.zero", W'(zero), '0);
      chk("rdiv.busy", W'(busy), '0);
      chk("rdiv.in_ready", W'(in_ready), 32'd1);
      #2;
      rst_n = 1'b1;
      tick();
      run(ALU_ADD, 32'd2, 32'd2, 32'd4, 0, "post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
